// File: rtl/ysyx_23060337_fetch_ctrl_if.sv
// Fetch controller bus bundle: instruction-memory request/response channels,
// the instruction handoff toward the IDU and the execute-stage redirect.
// master = fetch controller side, slave = memory/IDU/EXU environment side.
interface ysyx_23060337_fetch_ctrl_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_err;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output imem_req_valid,
        input  imem_req_ready,
        output imem_req_addr,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        input  imem_rsp_err,
        output inst_valid,
        input  inst_ready,
        output inst,
        output inst_pc,
        output inst_err,
        input  redirect_valid,
        input  redirect_pc
    );

    modport slave (
        input  imem_req_valid,
        output imem_req_ready,
        input  imem_req_addr,
        output imem_rsp_valid,
        output imem_rsp_data,
        output imem_rsp_err,
        input  inst_valid,
        output inst_ready,
        input  inst,
        input  inst_pc,
        input  inst_err,
        output redirect_valid,
        output redirect_pc
    );
endinterface

// File: rtl/ysyx_23060337_fetch_ctrl.sv
// Multi-cycle instruction fetch controller.
// Owns the PC, issues one word request at a time to instruction memory,
// holds the fetched word for the IDU and follows execute-stage redirects.
// Optional macro YSYX_23060337_FETCH_PERF_EN adds fetch/stall counters.
module ysyx_23060337_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                          clk,
    input  logic                          rst,
    ysyx_23060337_fetch_ctrl_if.master    bus
`ifdef YSYX_23060337_FETCH_PERF_EN
    ,
    output logic [31:0]                   perf_fetch_cnt,
    output logic [31:0]                   perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

    state_e      state_q,   state_d;
    logic [31:0] pc_q,      pc_d;
    logic        flush_q,   flush_d;
    logic [31:0] inst_q,    inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        inst_err_q, inst_err_d;

    // Redirect targets are word aligned; the low two bits are dropped.
    logic [31:0] redirect_tgt_s;
    assign redirect_tgt_s = {bus.redirect_pc[31:2], 2'b00};

    // Next-state, PC, flush and held-instruction computation.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        flush_d    = flush_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
        inst_err_d = inst_err_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
                if (bus.redirect_valid) begin
                    pc_d = redirect_tgt_s;
                end else begin
                    pc_d = pc_q;
                end
            end
            ST_REQ: begin
                if (bus.imem_req_ready) begin
                    // Request goes out with the current pc; a same-cycle
                    // redirect makes the coming response stale.
                    state_d = ST_WAIT;
                    if (bus.redirect_valid) begin
                        pc_d    = redirect_tgt_s;
                        flush_d = 1'b1;
                    end else begin
                        flush_d = 1'b0;
                    end
                end else if (bus.redirect_valid) begin
                    pc_d = redirect_tgt_s;
                end else begin
                    pc_d = pc_q;
                end
            end
            ST_WAIT: begin
                if (bus.imem_rsp_valid) begin
                    if (bus.redirect_valid) begin
                        pc_d    = redirect_tgt_s;
                        flush_d = 1'b0;
                        state_d = ST_REQ;
                    end else if (flush_q) begin
                        flush_d = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        inst_d     = bus.imem_rsp_data;
                        inst_pc_d  = pc_q;
                        inst_err_d = bus.imem_rsp_err;
                        state_d    = ST_HOLD;
                    end
                end else if (bus.redirect_valid) begin
                    // Response still owed for the old address: drop it later.
                    pc_d    = redirect_tgt_s;
                    flush_d = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (bus.redirect_valid) begin
                    pc_d       = redirect_tgt_s;
                    state_d    = ST_REQ;
                    inst_d     = NOP_INST;
                    inst_err_d = 1'b0;
                end else if (bus.inst_ready) begin
                    pc_d       = pc_q + 32'd4;
                    state_d    = ST_REQ;
                    inst_d     = NOP_INST;
                    inst_err_d = 1'b0;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                flush_d    = 1'b0;
                inst_d     = NOP_INST;
                inst_err_d = 1'b0;
            end
        endcase
    end

    // Controller state registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            flush_q    <= 1'b0;
            inst_q     <= NOP_INST;
            inst_pc_q  <= RESET_PC;
            inst_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            flush_q    <= flush_d;
            inst_q     <= inst_d;
            inst_pc_q  <= inst_pc_d;
            inst_err_q <= inst_err_d;
        end
    end

    // Outputs are decoded straight from flops so they follow reset at once.
    assign bus.imem_req_valid = (state_q == ST_REQ);
    assign bus.imem_req_addr  = pc_q;
    assign bus.inst_valid     = (state_q == ST_HOLD);
    assign bus.inst           = inst_q;
    assign bus.inst_pc        = inst_pc_q;
    assign bus.inst_err       = inst_err_q;

`ifdef YSYX_23060337_FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Count consumed instructions and cycles spent waiting on memory.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if ((state_q == ST_HOLD) && bus.inst_ready) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end else begin
            fetch_cnt_d = fetch_cnt_q;
        end
        if ((state_q == ST_WAIT) || ((state_q == ST_REQ) && !bus.imem_req_ready)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/ysyx_23060337_fetch_ctrl.md
Name: ysyx_23060337_fetch_ctrl

Overview:
- Multi-cycle instruction fetch controller. Owns the PC register and replaces the free-running PC plus combinational IFU path.
- Issues word requests to instruction memory over a valid/ready request channel and a valid-only response channel.
- Holds each fetched instruction under a valid/ready handshake toward the IDU.
- Accepts control-flow redirects from the execute stage.

Parameters:
- RESET_PC, 32'h80000000, PC value loaded on reset.
- NOP_INST, 32'h00000013, value of inst while no valid instruction is held (addi x0,x0,0).

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request
- imem_req_addr  output  32  fetch address, always equals pc
- imem_rsp_valid  input  1  response data valid, one-cycle pulse
- imem_rsp_data  input  32  fetched word
- imem_rsp_err  input  1  access fault for this response
- inst_valid  output  1  instruction held for IDU
- inst_ready  input  1  IDU/EXU consumes instruction
- inst  output  32  held instruction
- inst_pc  output  32  PC of held instruction
- inst_err  output  1  held instruction carries access fault
- redirect_valid  input  1  control-flow change
- redirect_pc  input  32  target PC

Behaviour:
- Interface decision: one clock, clk; reset rst is asynchronous and active-high. All state flops reset asynchronously on rst high.
- Reset values:
  - state=IDLE, pc=RESET_PC, flush=0.
  - inst=NOP_INST, inst_pc=RESET_PC, inst_err=0.
  - imem_req_valid=0, inst_valid=0.
- Output decoding:
  - imem_req_valid=1 only in REQ.
  - inst_valid=1 only in HOLD.
  - imem_req_addr=pc, combinational.
- State IDLE: unconditionally goes to REQ next cycle. A redirect seen in IDLE updates pc.
- State REQ:
  - imem_req_valid=1.
  - Handshake (valid&ready) goes to WAIT.
  - redirect without handshake: pc<=redirect_pc, stay REQ. The address may change while valid; the instruction memory is SRAM-like and tolerates this.
  - redirect with handshake in the same cycle: request is accepted with the old pc. pc<=redirect_pc, flush<=1, go WAIT.
- State WAIT:
  - rsp_valid with flush=0: inst<=rsp_data, inst_pc<=pc, inst_err<=rsp_err, go HOLD.
  - rsp_valid with flush=1: discard response, flush<=0, go REQ.
  - redirect without rsp_valid: pc<=redirect_pc, flush<=1, stay WAIT.
  - redirect with rsp_valid: discard response, pc<=redirect_pc, flush<=0, go REQ.
- State HOLD:
  - inst_valid=1. inst, inst_pc and inst_err stay stable until consumed.
  - inst_ready without redirect: pc<=pc+4, go REQ.
  - redirect, with or without inst_ready: pc<=redirect_pc, go REQ. Held instruction is dropped if not consumed.
  - On leaving HOLD, inst returns to NOP_INST and inst_err to 0.
- Arithmetic:
  - pc+4 is 32-bit, wraps 32'hFFFFFFFC -> 32'h00000000.
  - redirect_pc[1:0] are forced to 0 when loaded.
- Latency: with zero-wait memory (ready=1, response the cycle after accept) and ready IDU, one instruction per 3 cycles (REQ, WAIT, HOLD).
- Never more than one outstanding memory request. imem_rsp_valid outside WAIT is ignored.
- Reset mid-operation: immediate return to reset values. Any in-flight response after reset release is ignored, because the state is not WAIT.

Optional Feature:
- Macro: YSYX_23060337_FETCH_PERF_EN.
- When defined, two extra outputs:
  - perf_fetch_cnt[31:0]: increments on each HOLD consume (inst_valid&inst_ready).
  - perf_stall_cnt[31:0]: increments each cycle in WAIT, or in REQ with imem_req_ready=0.
- Both counters reset to 0, wrap at 2^32 and are unaffected by redirect.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset release, mem ready=1, rsp 1 cycle later with data 32'h00000093, inst_ready=1 -> first req_addr 0x80000000 in cycle 1; inst_valid with inst=0x00000093 and inst_pc=0x80000000 in cycle 3; next req_addr 0x80000004.
- inst_ready=0 for 5 cycles in HOLD -> inst, inst_pc and inst_valid stable; no new request; pc advances only on the consume cycle.
- Redirect to 0x80000100 during WAIT, rsp data 0xDEADBEEF -> response dropped, inst_valid stays 0, next req_addr 0x80000100.
- Redirect 0x80000203 coincident with rsp_valid in WAIT -> response dropped, next req_addr 0x80000200.
- pc=0xFFFFFFFC consumed -> next req_addr 0x00000000. rsp_err=1 -> inst_err=1 with the instruction, cleared after consume.
- rst asserted while in WAIT -> outputs at reset values in the same cycle; a late rsp_valid after release produces no inst_valid. With PERF_EN, counters read 0.
